// File: rtl/ibpl_pkg.sv
// ibpl_pkg: shared state encoding, slot pin indices and reserved cardlet IDs
package ibpl_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, SHIFT, CHECK, DONE} state_t;
  localparam int IBPL_PIN_SCK = 0;
  localparam int IBPL_PIN_LOADN = 1;
  localparam int IBPL_PIN_SDATA = 2;
  localparam logic [7:0] IBPL_ID_ABSENT = 8'hFF;
  localparam logic [7:0] IBPL_ID_EMPTY = 8'h00;
endpackage

// File: rtl/ibpl_serial_rx.sv
// ibpl_serial_rx: one 165-style ID read (go -> LOAD, SETTLE, SHIFT -> done) producing sck/load_n and the shifted-in data
module ibpl_serial_rx
  import ibpl_pkg::*;
#(
  parameter int SCK_DIV = 62,
  parameter int SETTLE_CYCLES = 16,
  parameter int ID_BITS = 8
) (
  input  logic               clk,
  input  logic               nReset,
  input  logic               go,
  input  logic               sdata,
  output logic               done,
  output logic               sck,
  output logic               load_n,
  output logic [ID_BITS-1:0] data
);
  localparam int CMAX = SCK_DIV > SETTLE_CYCLES ? SCK_DIV : SETTLE_CYCLES;
  localparam int CW = $clog2(CMAX);
  localparam int BW = $clog2(ID_BITS + 1);
  localparam logic [CW-1:0] D_END = CW'(SCK_DIV - 1);
  localparam logic [CW-1:0] S_END = CW'(SETTLE_CYCLES - 1);
  localparam logic [BW-1:0] B_END = BW'(ID_BITS - 1);
  state_t st, nxt;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bits;
  logic [1:0] sync;
  logic d_end;
  assign d_end = cnt == D_END;
  assign done = st == SHIFT && sck && d_end && bits == B_END;
  always_comb begin
    nxt = st == IDLE   ? (go ? LOAD : IDLE) :
          st == LOAD   ? (d_end ? SETTLE : LOAD) :
          st == SETTLE ? (cnt == S_END ? SHIFT : SETTLE) :
          st == SHIFT  ? (done ? IDLE : SHIFT) : IDLE;
  end
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      st <= IDLE;
      cnt <= '0;
      bits <= '0;
      sync <= '0;
      sck <= 1'b0;
      load_n <= 1'b1;
      data <= '0;
    end else begin
      st <= nxt;
      sync <= {sync[0], sdata};
      cnt <= (st == IDLE || nxt != st || (st == SHIFT && d_end)) ? '0 : cnt + CW'(1);
      load_n <= nxt != LOAD;
      sck <= (st == SHIFT && d_end) ? !sck : sck;
      bits <= st != SHIFT ? '0 : (d_end && sck) ? bits + BW'(1) : bits;
      if (st == SHIFT && d_end && !sck) data <= {data[ID_BITS-2:0], sync[1]};
    end
  end
endmodule

// File: rtl/ibpl_cardlet_ident.sv
// ibpl_cardlet_ident: reads the slot cardlet ID twice via ibpl_serial_rx, retries on mismatch, owns diob pins only while busy
module ibpl_cardlet_ident
  import ibpl_pkg::*;
#(
  parameter int SCK_DIV = 62,
  parameter int SETTLE_CYCLES = 16,
  parameter int ID_BITS = 8,
  parameter int MAX_RETRIES = 3
) (
  input  logic               clk,
  input  logic               nReset,
  input  logic               start,
  input  logic [5:0]         diob_in,
  output logic [5:0]         diob_dir,
  output logic [5:0]         diob_out,
  output logic [ID_BITS-1:0] cardlet_id,
  output logic               id_valid,
  output logic               busy,
  output logic               id_error
);
  localparam int RW = $clog2(MAX_RETRIES + 1);
  state_t st, nxt;
  logic go, accept, rx_done, sck, load_n, have_ref, match, last_try;
  logic [ID_BITS-1:0] rx_data, ref_reg;
  logic [RW-1:0] retry_cnt;
  logic unused_pins;
  assign unused_pins = ^{diob_in[5:3], diob_in[1:0]};
  ibpl_serial_rx #(.SCK_DIV(SCK_DIV), .SETTLE_CYCLES(SETTLE_CYCLES), .ID_BITS(ID_BITS)) u_rx (
    .clk(clk), .nReset(nReset), .go(go), .sdata(diob_in[IBPL_PIN_SDATA]),
    .done(rx_done), .sck(sck), .load_n(load_n), .data(rx_data)
  );
  assign accept = (st == IDLE || st == DONE) && start;
  assign match = rx_data == ref_reg;
  assign last_try = retry_cnt == RW'(MAX_RETRIES - 1);
  assign busy = st == LOAD || st == CHECK;
  assign diob_dir = busy ? 6'h03 : 6'h00;
  assign diob_out = busy ? ((6'(sck) << IBPL_PIN_SCK) | (6'(load_n) << IBPL_PIN_LOADN)) : 6'h00;
  always_comb begin
    nxt = st;
    go = 1'b0;
    case (st)
      IDLE, DONE: begin
        go = start;
        nxt = start ? LOAD : st;
      end
      LOAD: nxt = rx_done ? CHECK : LOAD;
      CHECK: begin
        go = !have_ref || (!match && !last_try);
        nxt = go ? LOAD : DONE;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) st <= IDLE;
    else st <= nxt;
  end
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      ref_reg <= '0;
      have_ref <= 1'b0;
      retry_cnt <= '0;
      cardlet_id <= '0;
      id_valid <= 1'b0;
      id_error <= 1'b0;
    end else if (accept) begin
      have_ref <= 1'b0;
      retry_cnt <= '0;
      id_valid <= 1'b0;
      id_error <= 1'b0;
    end else if (st == CHECK) begin
      have_ref <= !have_ref;
      if (!have_ref) ref_reg <= rx_data;
      else if (match) begin
        cardlet_id <= rx_data;
        id_valid <= 1'b1;
      end else begin
        retry_cnt <= retry_cnt + RW'(1);
        id_error <= last_try;
      end
    end
  end
endmodule

// File: tb/tb_ibpl_cardlet_ident.sv
// tb_ibpl_cardlet_ident: random and directed ID reads against a pair/retry reference model with per-cycle output checks
module tb_ibpl_cardlet_ident;
  localparam int D = 4, S = 4, N = 8, MR = 3;
  localparam int R = D + S + 2 * N * D;
  localparam int PAIR = 2 * R + 2;
  logic clk = 0, nReset = 0, start = 0;
  logic [5:0] diob_in, diob_dir, diob_out;
  logic [7:0] cardlet_id;
  logic id_valid, busy, id_error;
  int total = 0, bad = 0, sck_rises = 0, cyc;
  always #5 clk = ~clk;
  ibpl_cardlet_ident #(.SCK_DIV(D), .SETTLE_CYCLES(S), .ID_BITS(N), .MAX_RETRIES(MR)) dut (
    .clk(clk), .nReset(nReset), .start(start), .diob_in(diob_in), .diob_dir(diob_dir),
    .diob_out(diob_out), .cardlet_id(cardlet_id), .id_valid(id_valid), .busy(busy), .id_error(id_error)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      if (bad <= 40) $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask
  logic [7:0] seq [64];
  bit present = 1, prev_load = 0, prev_sck = 0, loading;
  int rd_idx = 0;
  logic [7:0] csr = 8'hFF;
  function automatic logic [7:0] rv(input int i);
    return present ? seq[i % 64] : 8'hFF;
  endfunction
  always @(negedge clk) begin
    loading = diob_dir[1] && !diob_out[1];
    if (loading && !prev_load) begin
      csr = rv(rd_idx);
      rd_idx++;
    end else if (!loading && diob_out[0] && !prev_sck) csr = {csr[6:0], 1'b1};
    prev_load = loading;
    prev_sck = diob_out[0];
  end
  assign diob_in = {3'b000, present ? csr[7] : 1'b1, 2'b00};
  always @(posedge diob_out[0]) sck_rises++;
  int m_left = 0;
  logic [7:0] m_id = 0, m_nid = 0;
  bit m_valid = 0, m_err = 0, m_nvalid = 0, m_nerr = 0;
  task automatic predict(input int base);
    int p = base, fails = 0;
    logic [7:0] a, b;
    m_left = 0;
    forever begin
      a = rv(p);
      b = rv(p + 1);
      p += 2;
      m_left += PAIR;
      if (a == b) begin
        m_nid = a; m_nvalid = 1; m_nerr = 0;
        break;
      end
      fails++;
      if (fails == MR) begin
        m_nid = m_id; m_nvalid = 0; m_nerr = 1;
        break;
      end
    end
  endtask
  always @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      m_left = 0; m_id = 0; m_valid = 0; m_err = 0;
    end else if (m_left == 0) begin
      if (start) begin
        m_valid = 0; m_err = 0;
        predict(rd_idx);
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_id = m_nid; m_valid = m_nvalid; m_err = m_nerr;
      end
    end
  end
  always @(negedge clk) begin
    chk("cyc_busy", 32'(busy), 32'(m_left > 0));
    chk("cyc_dir", 32'(diob_dir), m_left > 0 ? 32'h3 : 32'h0);
    chk("cyc_out_mask", 32'(diob_out & ~diob_dir), 32'h0);
    chk("cyc_id", 32'(cardlet_id), 32'(m_id));
    chk("cyc_valid", 32'(id_valid), 32'(m_valid));
    chk("cyc_err", 32'(id_error), 32'(m_err));
  end
  task automatic put(input int k, input logic [7:0] v);
    seq[(rd_idx + k) % 64] = v;
  endtask
  task automatic run_id(input int extra_at, output int c);
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    c = 0;
    while (busy && c < 3000) begin
      c++;
      start = (c == extra_at);
      @(negedge clk);
    end
    start = 0;
  endtask
  initial begin
    logic [7:0] v;
    int r;
    for (int k = 0; k < 64; k++) seq[k] = 8'hA5;
    repeat (3) @(negedge clk);
    chk("rst_dir", 32'(diob_dir), 0);
    chk("rst_out", 32'(diob_out), 0);
    chk("rst_id", 32'(cardlet_id), 0);
    nReset = 1;
    @(negedge clk);
    sck_rises = 0;
    put(0, 8'hA5); put(1, 8'hA5);
    run_id(-1, cyc);
    chk("a5_busy_cycles", cyc, 146);
    chk("a5_sck_rises", sck_rises, 16);
    chk("a5_id", 32'(cardlet_id), 32'hA5);
    chk("a5_valid", 32'(id_valid), 1);
    chk("a5_dir", 32'(diob_dir), 0);
    present = 0;
    run_id(-1, cyc);
    chk("absent_id", 32'(cardlet_id), 32'hFF);
    chk("absent_valid", 32'(id_valid), 1);
    chk("absent_err", 32'(id_error), 0);
    present = 1;
    put(0, 8'h3C); put(1, 8'h3D); put(2, 8'h3C); put(3, 8'h3C);
    run_id(-1, cyc);
    chk("retry_busy_cycles", cyc, 292);
    chk("retry_id", 32'(cardlet_id), 32'h3C);
    for (int k = 0; k < 6; k++) put(k, k % 2 ? 8'h22 : 8'h11);
    run_id(-1, cyc);
    chk("err_busy_cycles", cyc, 3 * 146);
    chk("err_flag", 32'(id_error), 1);
    chk("err_valid", 32'(id_valid), 0);
    chk("err_id_held", 32'(cardlet_id), 32'h3C);
    chk("err_dir", 32'(diob_dir), 0);
    put(0, 8'hA5); put(1, 8'hA5);
    run_id(40, cyc);
    chk("ign_busy_cycles", cyc, 146);
    chk("ign_id", 32'(cardlet_id), 32'hA5);
    put(0, 8'h5A); put(1, 8'h5A);
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    chk("redo_valid_drop", 32'(id_valid), 0);
    chk("redo_busy", 32'(busy), 1);
    cyc = 0;
    while (busy && cyc < 3000) begin cyc++; @(negedge clk); end
    chk("redo_busy_cycles", cyc, 146);
    chk("redo_id", 32'(cardlet_id), 32'h5A);
    put(0, 8'h77); put(1, 8'h77);
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    repeat (30) @(negedge clk);
    #2 nReset = 0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_dir", 32'(diob_dir), 0);
    chk("arst_out", 32'(diob_out), 0);
    chk("arst_id", 32'(cardlet_id), 0);
    chk("arst_valid", 32'(id_valid), 0);
    @(negedge clk) nReset = 1;
    put(0, 8'hC3); put(1, 8'hC3);
    run_id(-1, cyc);
    chk("post_rst_id", 32'(cardlet_id), 32'hC3);
    chk("post_rst_valid", 32'(id_valid), 1);
    for (int i = 0; i < 8; i++) begin
      v = 8'($urandom);
      r = $urandom_range(0, 2);
      if (r == 0) begin put(0, v); put(1, v); end
      else if (r == 1) begin
        put(0, v); put(1, v ^ 8'(1 << $urandom_range(0, 7))); put(2, v); put(3, v);
      end else for (int k = 0; k < 6; k++) put(k, k % 2 ? ~v : v);
      run_id(-1, cyc);
      chk("rnd_busy_cycles", cyc, (r + 1) * PAIR);
      chk("rnd_valid", 32'(id_valid), 32'(r < 2));
      if (r < 2) chk("rnd_id", 32'(cardlet_id), 32'(v));
    end
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
